sevenseg_scan_ctrl: RTL
=======================

Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a shared seven-segment bus driving NUM_DIGITS common-select digits.
- Holds one 4-bit hex value plus a blank flag per digit, written through a simple write port by upstream logic (gate outputs, counters).
- Sequences the digits with a programmable refresh divider and a dead-time blanking interval between digits to prevent ghosting.
- Decodes the full hex range 0-F to registered segment outputs.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- ADDR_W, 2, width of wr_addr; must satisfy 2^ADDR_W >= NUM_DIGITS.
- REFRESH_DIV, 50000, clk cycles per digit slot including dead time (>= DEADTIME+2).
- DEADTIME, 4, clk cycles of blanking at the start of each slot (>= 1).
- SEG_ACTIVE_LOW, 1, 1 = segment on drives 0.
- DIGIT_ACTIVE_LOW, 0, 1 = selected digit drives 0.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, scan enable; low forces display dark.
- wr_en, input, 1, write strobe for the digit value registers.
- wr_addr, input, ADDR_W, target digit index.
- wr_data, input, 4, hex value 0-F.
- wr_blank, input, 1, 1 = digit shows no segments.
- seg, output, 7, segments {g,f,e,d,c,b,a} (bit0 = a), polarity per SEG_ACTIVE_LOW.
- digit, output, NUM_DIGITS, one-hot digit select, polarity per DIGIT_ACTIVE_LOW.
- scan_idx, output, ADDR_W, index of the digit currently owning the bus.
- frame_done, output, 1, one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - div_cnt=0; scan_idx=0; state=BLANK.
  - All value regs = 0 with blank = 1.
  - seg = all-off, digit = all-inactive, frame_done = 0.
- Divider: div_cnt counts 0..REFRESH_DIV-1 and wraps to 0. Slot end is div_cnt==REFRESH_DIV-1.
- FSM states:
  - IDLE: en=0. Outputs inactive; div_cnt and scan_idx held at 0.
  - BLANK: div_cnt < DEADTIME. seg all-off, digit all-inactive.
  - DRIVE: DEADTIME <= div_cnt <= REFRESH_DIV-1. digit[scan_idx] active, seg = decode(value[scan_idx]).
- Transitions:
  - IDLE -> BLANK when en=1, div_cnt starting at 0.
  - BLANK -> DRIVE when div_cnt reaches DEADTIME.
  - DRIVE -> BLANK at slot end. On that edge scan_idx increments, wrapping NUM_DIGITS-1 -> 0.
  - Any state -> IDLE when en=0 (next cycle, outputs dark).
- frame_done is asserted in the cycle after the slot end of scan_idx==NUM_DIGITS-1, for exactly one cycle.
- seg and digit are registered. They reflect state/scan_idx/value with 1-cycle latency, so digit becomes active at div_cnt==DEADTIME+1 relative to the divider.
- Writes:
  - Registered on wr_en at the clock edge.
  - wr_addr >= NUM_DIGITS is ignored; no register changes.
  - A write to the currently driven digit updates seg two edges after the write edge (value reg, then output reg). There is no glitch to all-off.
  - Write and slot advance in the same cycle: both take effect; the write is not lost.
- Decode:
  - Standard hex patterns (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
  - Inverted when SEG_ACTIVE_LOW=1.
  - blank=1 yields all-off regardless of value.
- Reset mid-slot: outputs go dark immediately (async); the scan restarts from digit 0 with a BLANK slot.

Test Plan:
- Reset, then en=1, no writes (REFRESH_DIV=8, DEADTIME=2, NUM_DIGITS=4) -> digit cycles through each index for 6 cycles per 8-cycle slot; seg=7'h7F (off, active-low) throughout; frame_done pulses once every 32 cycles.
- Write addr0=1, addr1=A, addr2=F, addr3=0 with blank=0 -> slot 0 seg=7'h79, slot1 7'h08, slot2 7'h0E, slot3 7'h40; digit one-hot 0001/0010/0100/1000; never two digits active.
- Dead-time check -> for 2 cycles after every slot boundary, digit=0000 and seg=7'h7F.
- Write addr1=3 during slot 1 DRIVE -> seg changes 7'h08 -> 7'h30 exactly two edges later; wr_addr=5 (ADDR_W=3, NUM_DIGITS=4) leaves all values unchanged.
- Deassert en mid-DRIVE of digit 2 -> next cycle digit=0000, seg off; re-enable -> scan restarts at digit 0 with a BLANK slot.
- Assert rst mid-DRIVE -> outputs dark without waiting for a clk edge; after release, all digits blank and scan_idx=0.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// sevenseg_scan_ctrl: multiplexed 7-segment scan controller with hex decode
// and per-slot dead-time blanking.  Rev 1.0
// ============================================================================
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS       = 4,
  parameter int ADDR_W           = 2,
  parameter int REFRESH_DIV      = 50000,
  parameter int DEADTIME         = 4,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_blank,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit,
  output logic [ADDR_W-1:0]     scan_idx,
  output logic                  frame_done
);

  localparam int                    DIV_W      = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0]      C_DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0]      C_DEAD     = DIV_W'(DEADTIME);
  localparam logic [ADDR_W-1:0]     C_IDX_LAST = ADDR_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF  = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [DIV_W-1:0]             div_cnt_q, div_cnt_d;
  logic [ADDR_W-1:0]            scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0][3:0]   value_q, value_d;
  logic [NUM_DIGITS-1:0]        blank_q, blank_d;
  logic [6:0]                   seg_q, seg_d;
  logic [NUM_DIGITS-1:0]        digit_q, digit_d;
  logic                         frame_done_q, frame_done_d;

  logic [3:0]                   sel_value;
  logic                         sel_blank;
  logic [NUM_DIGITS-1:0]        sel_onehot;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Divider / scan sequencing; state tracks the divider value it will hold.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    scan_idx_d = scan_idx_q;
    if (!en) begin
      state_d    = ST_IDLE;
      div_cnt_d  = '0;
      scan_idx_d = '0;
    end else if (state_q == ST_IDLE) begin
      state_d    = ST_BLANK;
      div_cnt_d  = '0;
      scan_idx_d = '0;
    end else begin
      if (div_cnt_q == C_DIV_LAST) begin
        div_cnt_d  = '0;
        scan_idx_d = (scan_idx_q == C_IDX_LAST) ? '0 : scan_idx_q + 1'b1;
      end else begin
        div_cnt_d  = div_cnt_q + 1'b1;
      end
      state_d = (div_cnt_d < C_DEAD) ? ST_BLANK : ST_DRIVE;
    end
  end

  // Out-of-range addresses never match any digit, so they are dropped here.
  always_comb begin
    value_d    = value_q;
    blank_d    = blank_q;
    sel_value  = 4'h0;
    sel_blank  = 1'b1;
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        value_d[i] = wr_data;
        blank_d[i] = wr_blank;
      end
      if (scan_idx_q == ADDR_W'(i)) begin
        sel_value     = value_q[i];
        sel_blank     = blank_q[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Outputs are gated by en as well so a disable darkens on the next edge.
  always_comb begin
    seg_d        = SEG_OFF;
    digit_d      = DIGIT_OFF;
    frame_done_d = 1'b0;
    if (en && (state_q == ST_DRIVE)) begin
      seg_d        = sel_blank ? SEG_OFF : (hex_decode(sel_value) ^ {7{SEG_ACTIVE_LOW}});
      digit_d      = sel_onehot ^ DIGIT_OFF;
      frame_done_d = (div_cnt_q == C_DIV_LAST) && (scan_idx_q == C_IDX_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      div_cnt_q    <= '0;
      scan_idx_q   <= '0;
      value_q      <= '0;
      blank_q      <= '1;
      seg_q        <= SEG_OFF;
      digit_q      <= DIGIT_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      scan_idx_q   <= scan_idx_d;
      value_q      <= value_d;
      blank_q      <= blank_d;
      seg_q        <= seg_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign digit      = digit_q;
  assign scan_idx   = scan_idx_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
